pipe_skid_reg: RTL

Parametrised pipeline-stage register with a valid/ready handshake. It adds a two-entry skid buffer so the ready path is fully registered. It also provides a flush and a programmable reset value. It sits between CPU pipeline stages (e.g. IF/ID, ID/EX) and replaces bare enable-registers wherever backpressure or squash is needed.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_skid_reg.sv | 103 ++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Types shared by the pipeline-stage register: occupancy state encoding and
// the width of the occupancy count.
package pipe_pkg;

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid
// register, so in_ready depends only on registered state, never on out_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             out_fire;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL);
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    count = '0;
    case (state)
      ST_BUSY: count = CNT_W'(1);
      ST_FULL: count = CNT_W'(2);
      default: count = '0;
    endcase
  end

  // The skid register is only written when main is occupied and not draining;
  // main refills from skid when the head entry leaves a full stage.
  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main  = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          state_next = ST_FULL;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_next     = ST_BUSY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // Flush squashes everything held, including a same-cycle arrival.
    if (flush) begin
      state_next = ST_EMPTY;
      load_main  = 1'b0;
      load_skid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else begin
      state <= state_next;
      if (load_main) begin
        main_data <= main_from_skid ? skid_data : in_data;
      end
      if (load_skid) begin
        skid_data <= in_data;
      end
    end
  end

endmodule
